// File: rtl/arithmetic_engine_pipe.sv
// Arithmetic/logic engine with a valid/ready handshake on both sides.
// Logic ops, ADD, SUB and the illegal opcode finish in one cycle; MUL iterates one shift-add step per clock.
module arithmetic_engine_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             err
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state, state_next;

   logic             accept;
   logic             mul_last;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    step_cnt;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic             alu_ovf;
   logic             alu_err;

   // A slot opens when idle, or when the held result is retired this same edge.
   assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
   assign accept   = in_valid && in_ready;
   assign mul_last = (state == BUSY) && (step_cnt == CW'(WIDTH - 1));
   assign acc_step = mplier[0] ? (acc + mcand) : acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = (opcode == 3'd6) ? BUSY : DONE;
         BUSY: if (mul_last) state_next = DONE;
         DONE: begin
            if (out_ready) begin
               if (accept) state_next = (opcode == 3'd6) ? BUSY : DONE;
               else        state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Single-cycle datapath; the borrow of SUB falls out as the extra sum bit.
   always_comb begin
      sum        = {1'b0, A} + {1'b0, B};
      diff       = {1'b0, A} - {1'b0, B};
      alu_result = '0;
      alu_carry  = 1'b0;
      alu_ovf    = 1'b0;
      alu_err    = 1'b0;
      case (opcode)
         3'd0: alu_result = A | B;
         3'd1: alu_result = ~(A & B);
         3'd2: alu_result = ~(A | B);
         3'd3: alu_result = A & B;
         3'd4: begin
            alu_result = sum[WIDTH-1:0];
            alu_carry  = sum[WIDTH];
            alu_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         3'd5: begin
            alu_result = diff[WIDTH-1:0];
            alu_carry  = diff[WIDTH];
            alu_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         3'd7:    alu_err = 1'b1;
         default: alu_err = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
         err       <= 1'b0;
         mcand     <= '0;
         acc       <= '0;
         mplier    <= '0;
         step_cnt  <= '0;
      end else if (accept) begin
         if (opcode == 3'd6) begin
            mcand     <= {{WIDTH{1'b0}}, A};
            mplier    <= B;
            acc       <= '0;
            step_cnt  <= '0;
            out_valid <= 1'b0;
         end else begin
            result    <= alu_result;
            flags     <= {alu_carry, alu_ovf, alu_result[WIDTH-1], (alu_result == '0)};
            err       <= alu_err;
            out_valid <= 1'b1;
         end
      end else if (state == BUSY) begin
         acc      <= acc_step;
         mcand    <= mcand << 1;
         mplier   <= mplier >> 1;
         step_cnt <= step_cnt + CW'(1);
         if (mul_last) begin
            result    <= acc_step[WIDTH-1:0];
            flags     <= {(|acc_step[2*WIDTH-1:WIDTH]), 1'b0, acc_step[WIDTH-1],
                          (acc_step[WIDTH-1:0] == '0)};
            err       <= 1'b0;
            out_valid <= 1'b1;
         end
      end else if ((state == DONE) && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_arithmetic_engine_pipe.sv
// Directed bench for arithmetic_engine_pipe at WIDTH=8 with hand-computed results.
module tb_arithmetic_engine_pipe;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] A = '0;
   logic [7:0] B = '0;
   logic [2:0] opcode = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] result;
   logic [3:0] flags;
   logic       err;

   logic [13:0] obs;
   int checks = 0;
   int errors = 0;

   assign obs = {out_valid, result, flags, err};

   always #5 clk = ~clk;

   arithmetic_engine_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags), .err(err)
   );

   // Present one operation for a single edge; the caller ensures in_ready is high.
   task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      opcode = op; A = a; B = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({in_ready, obs} !== 15'd0) begin
         $display("[TB] FAIL reset_outputs got %h exp %h", {in_ready, obs}, 15'd0); errors++;
      end
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         $display("[TB] FAIL reset_release got %b exp %b", {in_ready, out_valid}, 2'b10); errors++;
      end
      applyStimulus(3'd4, 8'd1, 8'd2);
      checks++;
      if (obs !== {1'b1, 8'd3, 4'b0000, 1'b0}) begin
         $display("[TB] FAIL first_accept got %h exp %h", obs, {1'b1, 8'd3, 4'b0000, 1'b0}); errors++;
      end
      retire();
   endtask

   task automatic test_logic();
      logic [2:0] op[4]  = '{3'd0, 3'd1, 3'd2, 3'd3};
      logic [7:0] va[4]  = '{8'h0F, 8'hFF, 8'h0F, 8'h0F};
      logic [7:0] vb[4]  = '{8'hF0, 8'h0F, 8'h30, 8'hF0};
      logic [7:0] er[4]  = '{8'hFF, 8'hF0, 8'hC0, 8'h00};
      logic [3:0] ef[4]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(op[i], va[i], vb[i]);
         checks++;
         if (obs !== {1'b1, er[i], ef[i], 1'b0}) begin
            $display("[TB] FAIL logic_op%0d got %h exp %h", op[i], obs, {1'b1, er[i], ef[i], 1'b0}); errors++;
         end
         retire();
      end
   endtask

   task automatic test_addsub();
      logic [2:0] op[6]  = '{3'd4, 3'd5, 3'd5, 3'd4, 3'd4, 3'd5};
      logic [7:0] va[6]  = '{8'd200, 8'd5, 8'h80, 8'h7F, 8'hFF, 8'd7};
      logic [7:0] vb[6]  = '{8'd100, 8'd10, 8'h01, 8'h01, 8'h01, 8'd7};
      logic [7:0] er[6]  = '{8'd44, 8'd251, 8'h7F, 8'h80, 8'h00, 8'h00};
      logic [3:0] ef[6]  = '{4'b1000, 4'b1010, 4'b0100, 4'b0110, 4'b1001, 4'b0001};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(op[i], va[i], vb[i]);
         checks++;
         if (obs !== {1'b1, er[i], ef[i], 1'b0}) begin
            $display("[TB] FAIL addsub_%0d got %h exp %h", i, obs, {1'b1, er[i], ef[i], 1'b0}); errors++;
         end
         retire();
      end
   endtask

   // Operands are scrambled while busy to confirm they were captured at accept.
   task automatic mul_case(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] er, input logic [3:0] ef);
      applyStimulus(3'd6, a, b);
      opcode = 3'd0; A = 8'hFF; B = 8'hFF; in_valid = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({in_ready, out_valid} !== 2'b00) begin
            $display("[TB] FAIL mul_busy_%0d got %b exp %b", i, {in_ready, out_valid}, 2'b00); errors++;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (obs !== {1'b1, er, ef, 1'b0}) begin
         $display("[TB] FAIL mul_%0d_%0d got %h exp %h", a, b, obs, {1'b1, er, ef, 1'b0}); errors++;
      end
      retire();
   endtask

   task automatic test_mul();
      mul_case(8'd13, 8'd11, 8'd143, 4'b0010);
      mul_case(8'd16, 8'd16, 8'd0,   4'b1001);
      mul_case(8'hFF, 8'hFF, 8'h01,  4'b1000);
   endtask

   task automatic test_illegal();
      applyStimulus(3'd7, 8'h55, 8'hAA);
      checks++;
      if (obs !== {1'b1, 8'h00, 4'b0001, 1'b1}) begin
         $display("[TB] FAIL illegal got %h exp %h", obs, {1'b1, 8'h00, 4'b0001, 1'b1}); errors++;
      end
      retire();
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         $display("[TB] FAIL illegal_retire got %b exp %b", {in_ready, out_valid}, 2'b10); errors++;
      end
   endtask

   task automatic test_back_to_back();
      applyStimulus(3'd4, 8'd3, 8'd4);
      opcode = 3'd1; A = 8'hFF; B = 8'h0F; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({in_ready, obs} !== {1'b0, 1'b1, 8'd7, 4'b0000, 1'b0}) begin
            $display("[TB] FAIL hold_%0d got %h exp %h", i, {in_ready, obs}, {1'b0, 1'b1, 8'd7, 4'b0000, 1'b0}); errors++;
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         $display("[TB] FAIL b2b_ready got %b exp %b", in_ready, 1'b1); errors++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (obs !== {1'b1, 8'hF0, 4'b0010, 1'b0}) begin
         $display("[TB] FAIL b2b_nand got %h exp %h", obs, {1'b1, 8'hF0, 4'b0010, 1'b0}); errors++;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         $display("[TB] FAIL b2b_drain got %b exp %b", {in_ready, out_valid}, 2'b10); errors++;
      end
   endtask

   task automatic test_reset_busy();
      logic seen = 1'b0;
      applyStimulus(3'd6, 8'd13, 8'd11);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, obs} !== 15'd0) begin
         $display("[TB] FAIL rst_busy got %h exp %h", {in_ready, obs}, 15'd0); errors++;
      end
      @(posedge clk); #3 rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if ({seen, in_ready, obs} !== 16'h4000) begin
         $display("[TB] FAIL rst_busy_release got %h exp %h", {seen, in_ready, obs}, 16'h4000); errors++;
      end
      applyStimulus(3'd0, 8'h01, 8'h02);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (obs !== 14'd0) begin
         $display("[TB] FAIL rst_done got %h exp %h", obs, 14'd0); errors++;
      end
      #4 rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         $display("[TB] FAIL rst_done_release got %b exp %b", {in_ready, out_valid}, 2'b10); errors++;
      end
   endtask

   initial begin
      $display("[TB] start");
      test_reset();
      test_logic();
      test_addsub();
      test_mul();
      test_illegal();
      test_back_to_back();
      test_reset_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
